// File: rtl/poly_coeff_buffer.sv
// Receive-side buffer for the sampler's coefficient stream: fills N entries in order, then serves indexed reads.
// Optional build macro COEFF_RANGE_CHK_EN rejects coefficients >= Q and raises range_err.
module poly_coeff_buffer #(
    parameter int unsigned          COEFF_W = 24,
    parameter int unsigned          N       = 256,
    parameter logic [COEFF_W-1:0]   Q       = COEFF_W'(24'h7FE001)
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          clear,
    input  logic [COEFF_W-1:0]                            z_in,
    input  logic                                          z_valid,
    input  logic                                          poly_release,
    input  logic                                          rd_req,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0]          rd_addr,
    output logic [COEFF_W-1:0]                            rd_data,
    output logic                                          rd_valid,
    output logic [((N > 1) ? $clog2(N) : 1):0]            fill_count,
    output logic                                          poly_full,
    output logic                                          busy,
    output logic                                          overflow_err,
    output logic                                          range_err
);

    localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FILL  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             state;
    logic [COEFF_W-1:0] mem [N];

    logic in_range_c;
    logic accept_c;
    logic reject_c;
    logic last_c;

`ifdef COEFF_RANGE_CHK_EN
    assign in_range_c = (z_in < Q);
`else
    logic unused_q_c;
    assign unused_q_c = ^Q;
    assign in_range_c = 1'b1;
`endif

    // A word is stored only while filling, in range, and not being aborted.
    assign accept_c = z_valid && !clear && (state != S_FULL) && in_range_c;
    assign reject_c = z_valid && !clear && (state != S_FULL) && !in_range_c;
    assign last_c   = (fill_count == CW'(N - 1));

    // Storage has no reset; contents are meaningless until refilled.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            mem[fill_count[AW-1:0]] <= z_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_EMPTY;
            fill_count   <= '0;
            poly_full    <= 1'b0;
            busy         <= 1'b0;
            overflow_err <= 1'b0;
            range_err    <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
        end else if (clear) begin
            state        <= S_EMPTY;
            fill_count   <= '0;
            poly_full    <= 1'b0;
            busy         <= 1'b0;
            overflow_err <= 1'b0;
            range_err    <= 1'b0;
            rd_valid     <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (reject_c) begin
                range_err <= 1'b1;
            end
            unique case (state)
                S_EMPTY, S_FILL: begin
                    if (accept_c) begin
                        fill_count <= fill_count + CW'(1);
                        if (last_c) begin
                            state     <= S_FULL;
                            busy      <= 1'b0;
                            poly_full <= 1'b1;
                        end else begin
                            state <= S_FILL;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    if (z_valid) begin
                        overflow_err <= 1'b1;
                    end
                    if (rd_req) begin
                        rd_valid <= 1'b1;
                        rd_data  <= mem[rd_addr];
                    end
                    // Release and a same-cycle read both take effect.
                    if (poly_release) begin
                        state      <= S_EMPTY;
                        fill_count <= '0;
                        poly_full  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_coeff_buffer.sv
// Self-checking bench for poly_coeff_buffer: directed phases with random gaps/data against an array-based model.
module tb_poly_coeff_buffer;

    localparam int unsigned COEFF_W = 24;
    localparam int unsigned N       = 256;
    localparam logic [23:0] Q       = 24'h7FE001;
`ifdef COEFF_RANGE_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               clear;
    logic [23:0]        z_in;
    logic               z_valid;
    logic               poly_release;
    logic               rd_req;
    logic [7:0]         rd_addr;
    logic [23:0]        rd_data;
    logic               rd_valid;
    logic [8:0]         fill_count;
    logic               poly_full;
    logic               busy;
    logic               overflow_err;
    logic               range_err;

    int tests  = 0;
    int failed = 0;

    // Reference model: stored words, count and sticky flags.
    logic [23:0] ref_mem [N];
    int          ref_cnt = 0;
    bit          ref_ovf = 1'b0;
    bit          ref_rng = 1'b0;

    always #5 clk = ~clk;

    poly_coeff_buffer #(.COEFF_W(COEFF_W), .N(N), .Q(Q)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .z_in         (z_in),
        .z_valid      (z_valid),
        .poly_release (poly_release),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .fill_count   (fill_count),
        .poly_full    (poly_full),
        .busy         (busy),
        .overflow_err (overflow_err),
        .range_err    (range_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "/fill_count"}, 32'(fill_count), 32'(ref_cnt));
        check({tag, "/poly_full"},  32'(poly_full), 32'(ref_cnt == N));
        check({tag, "/busy"},       32'(busy), 32'(ref_cnt > 0 && ref_cnt < N));
        check({tag, "/overflow"},   32'(overflow_err), 32'(ref_ovf));
        check({tag, "/range"},      32'(range_err), 32'(ref_rng));
    endtask

    // One z_valid pulse, model update, status check, then a random 0-3 cycle gap.
    task automatic push(input logic [23:0] w, input string tag);
        z_in    = w;
        z_valid = 1'b1;
        tick();
        z_valid = 1'b0;
        if (ref_cnt == N) ref_ovf = 1'b1;
        else if (CHK && w >= Q) ref_rng = 1'b1;
        else begin
            ref_mem[ref_cnt] = w;
            ref_cnt++;
        end
        check_status(tag);
        repeat ($urandom_range(0, 3)) tick();
    endtask

    task automatic read1(input int addr, input string tag);
        rd_req  = 1'b1;
        rd_addr = 8'(addr);
        tick();
        rd_req  = 1'b0;
        check({tag, "/rd_valid"}, 32'(rd_valid), 32'd1);
        check({tag, "/rd_data"},  32'(rd_data), 32'(ref_mem[addr]));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        ref_cnt = 0;
        ref_ovf = 1'b0;
        ref_rng = 1'b0;
    endtask

    initial begin
        logic [23:0] last_rd;
        rst_n = 1'b0; clear = 1'b0; z_in = '0; z_valid = 1'b0;
        poly_release = 1'b0; rd_req = 1'b0; rd_addr = '0;
        repeat (3) tick();
        check_status("reset");
        check("reset/rd_valid", 32'(rd_valid), 32'd0);
        check("reset/rd_data",  32'(rd_data), 32'd0);
        rst_n = 1'b1;
        tick();

        // Fill with index values.
        for (int i = 0; i < N; i++) push(24'(i), "fill1");

        // Back-to-back reads of 0, 1, 255.
        rd_req = 1'b1; rd_addr = 8'd0;   tick();
        check("b2b0/valid", 32'(rd_valid), 32'd1);
        check("b2b0/data",  32'(rd_data), 32'h000000);
        rd_addr = 8'd1;   tick();
        check("b2b1/valid", 32'(rd_valid), 32'd1);
        check("b2b1/data",  32'(rd_data), 32'h000001);
        rd_addr = 8'd255; tick();
        check("b2b2/valid", 32'(rd_valid), 32'd1);
        check("b2b2/data",  32'(rd_data), 32'h0000FF);
        rd_req = 1'b0; tick();
        check("b2b/idle_valid", 32'(rd_valid), 32'd0);
        check("b2b/hold_data",  32'(rd_data), 32'h0000FF);

        // Overflow in FULL: word dropped, contents intact.
        push(24'h123456, "ovf");
        read1(0, "ovf_rd0");

        // Read together with release: read serviced, buffer emptied.
        rd_req = 1'b1; rd_addr = 8'd5; poly_release = 1'b1;
        tick();
        rd_req = 1'b0; poly_release = 1'b0;
        ref_cnt = 0;
        check("relrd/valid", 32'(rd_valid), 32'd1);
        check("relrd/data",  32'(rd_data), 32'h000005);
        check_status("release");
        last_rd = rd_data;

        // Reads outside FULL are ignored.
        rd_req = 1'b1; rd_addr = 8'd9; tick(); tick();
        rd_req = 1'b0;
        check("empty_rd/valid", 32'(rd_valid), 32'd0);
        check("empty_rd/data",  32'(rd_data), 32'(last_rd));

        // Refill with descending values; overflow stays sticky.
        for (int i = 0; i < N; i++) push(24'h7FE000 - 24'(i), "fill2");
        read1(0, "fill2_rd0");
        check("fill2/rd0_const", 32'(rd_data), 32'h7FE000);
        read1(255, "fill2_rd255");
        check("fill2/rd255_const", 32'(rd_data), 32'h7FDF01);
        do_clear();
        check_status("clear_ovf");

        // Out-of-range word while EMPTY.
        push(24'hFFFFFF, "empty_oor");

        // Partial fill with out-of-range injections, then clear with a same-cycle z_valid.
        for (int i = 0; i < 100; i++) begin
            if (i == 10) push(24'h7FE001, "inj_q");
            if (i == 50) push(24'hFFFFFF, "inj_max");
            push(24'($urandom % 32'(Q)), "fill3");
        end
        clear = 1'b1; z_valid = 1'b1; z_in = 24'h000055;
        tick();
        clear = 1'b0; z_valid = 1'b0;
        ref_cnt = 0; ref_ovf = 1'b0; ref_rng = 1'b0;
        check_status("clear_mid");
        rd_req = 1'b1; rd_addr = 8'd0; tick(); tick();
        rd_req = 1'b0;
        check("clear_rd/valid", 32'(rd_valid), 32'd0);

        // Random full fill with occasional out-of-range words, then random reads.
        for (int i = 0; ref_cnt < N; i++) begin
            if (i % 40 == 7) push(24'(Q + 24'($urandom_range(0, 1000))), "fill4_oor");
            else             push(24'($urandom % 32'(Q)), "fill4");
        end
        for (int k = 0; k < 64; k++) read1(int'($urandom_range(0, N - 1)), "rand_rd");

        // Release with a same-cycle z_valid: release wins, overflow set.
        poly_release = 1'b1; z_valid = 1'b1; z_in = 24'h000001;
        tick();
        poly_release = 1'b0; z_valid = 1'b0;
        ref_ovf = 1'b1; ref_cnt = 0;
        check_status("rel_z");

        // Asynchronous reset mid-fill.
        do_clear();
        for (int i = 0; i < 37; i++) push(24'(i * 3), "fill5");
        #2 rst_n = 1'b0;
        #1;
        ref_cnt = 0; ref_ovf = 1'b0; ref_rng = 1'b0;
        check_status("async_rst");
        check("async_rst/rd_valid", 32'(rd_valid), 32'd0);
        check("async_rst/rd_data",  32'(rd_data), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/poly_coeff_buffer.md
Name: poly_coeff_buffer

Overview:
- Receive end of the sampler's coefficient stream.
- Accepts one 24-bit coefficient per z_valid pulse from the rejection sampler.
- Stores coefficients in order into an N-entry polynomial buffer, then serves indexed reads to the downstream NTT/arithmetic stage through a request/valid handshake.
- The stream has no backpressure: the buffer must accept every valid word while filling, and flags any word that arrives when it cannot accept it.

Parameters:
- COEFF_W, 24, coefficient width in bits.
- N, 256, coefficients per polynomial (power of two).
- Q, 24'h7FE001, modulus; used only by the optional range check.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous abort; highest priority after reset.
- z_in  in  COEFF_W  incoming coefficient.
- z_valid  in  1  z_in valid this cycle (single-cycle qualifier, no ready).
- poly_release  in  1  consumer finished; return buffer to EMPTY.
- rd_req  in  1  read request.
- rd_addr  in  log2(N)  coefficient index to read.
- rd_data  out  COEFF_W  registered read data.
- rd_valid  out  1  rd_data valid (one-cycle pulse).
- fill_count  out  log2(N)+1  coefficients stored (0..N).
- poly_full  out  1  N coefficients held; reads permitted.
- busy  out  1  state is FILL.
- overflow_err  out  1  sticky: z_valid arrived while FULL.
- range_err  out  1  sticky: out-of-range coefficient (optional feature only).

Behaviour:
- Reset values (rst_n low, any state, including mid-fill):
  - state = EMPTY.
  - All outputs 0; write pointer 0.
  - Memory contents undefined, not cleared.
- States: EMPTY, FILL, FULL.
- EMPTY:
  - z_valid: write z_in at address 0, fill_count becomes 1, go to FILL. If N==1, go directly to FULL.
- FILL:
  - busy = 1.
  - Each z_valid writes at address fill_count[log2(N)-1:0], then fill_count increments.
  - Gaps of any length between z_valid pulses are allowed.
  - When the N-th word is written, go to FULL. poly_full is registered and rises the cycle after that write.
- FULL:
  - poly_full = 1; fill_count holds N.
  - z_valid: word dropped, overflow_err set (sticky), no state change.
  - rd_req: rd_data = mem[rd_addr] and rd_valid = 1 on the next clock edge; one read per cycle, back-to-back allowed.
  - poly_release: on the next edge go to EMPTY; fill_count = 0 and poly_full = 0 on that same edge.
- rd_req outside FULL: ignored; rd_valid stays 0 and rd_data holds its last value.
- rd_valid deasserts the cycle after any non-serviced cycle.
- Simultaneous rd_req and poly_release in FULL: the read is serviced (rd_valid pulses next cycle) and the release also takes effect.
- Simultaneous poly_release and z_valid in FULL: release wins; the word is dropped and overflow_err is set.
- poly_release outside FULL: ignored.
- clear (any state):
  - Next edge: state = EMPTY, fill_count = 0, poly_full = 0, busy = 0, overflow_err = 0, range_err = 0, rd_valid = 0.
  - A z_valid in the same cycle is not written.
- Errors are sticky until clear or reset; poly_release does not clear them.
- Write latency: coefficient readable one cycle after poly_full is observed high.
- Read latency: 1 cycle.
- Memory: single write port and single read port; the write and read sides never access concurrently by construction.

Optional Feature:
- Macro: COEFF_RANGE_CHK_EN.
- Defined:
  - In EMPTY/FILL, a z_valid with z_in >= Q is discarded: not written, fill_count not advanced.
  - range_err is set (sticky).
  - State is unchanged, except that EMPTY stays EMPTY.
- Not defined:
  - No comparison is performed; every accepted word is stored.
  - range_err is tied to 0.

Test Plan:
- Reset, then 256 z_valid pulses of value i (0..255) with random 0-3 cycle gaps -> busy high during fill; fill_count = 256; poly_full rises the cycle after the 256th write; overflow_err = 0.
- In FULL, rd_req with rd_addr = 0, 1, 255 back-to-back -> rd_valid high for 3 consecutive cycles, rd_data = 0x000000, 0x000001, 0x0000FF.
- In FULL, one z_valid with z_in = 0x123456 -> overflow_err = 1; reading addr 0 still returns 0x000000; fill_count = 256.
- poly_release, then refill with values 0x7FE000 - i -> addr 0 reads 0x7FE000 and addr 255 reads 0x7FDF01; overflow_err still 1 until clear; after clear, overflow_err = 0.
- Fill 100 words, then clear -> fill_count = 0, busy = 0; rd_req yields no rd_valid. Assert rst_n low mid-fill -> all outputs 0 immediately.
- With COEFF_RANGE_CHK_EN: inject 0x7FE001 and 0xFFFFFF among valid words -> both rejected, range_err = 1, fill_count advances only for words < Q. Without the macro the same stimulus is stored and range_err = 0.
